// File: rtl/aes_axis_host_pkg.sv
// aes_axis_host_pkg: frame constants, command codes, FSM states and byte-swap helper for the AES stream host
package aes_axis_host_pkg;
  localparam int WORD_S = 32;
  localparam int BYTE_S = 8;
  localparam int BLK_S = 128;
  localparam int CMD_FRAME_WORDS = 5;
  localparam int RSP_FRAME_WORDS = 4;
  localparam logic [WORD_S-1:0] ENCRYPT = 32'h0000_0001;
  localparam logic [WORD_S-1:0] SET_KEY = 32'h0000_0002;
  typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_e;
  function automatic logic [WORD_S-1:0] byteswap(input logic [WORD_S-1:0] w);
    return {w[BYTE_S-1:0], w[2*BYTE_S-1:BYTE_S], w[3*BYTE_S-1:2*BYTE_S], w[4*BYTE_S-1:3*BYTE_S]};
  endfunction
endpackage

// File: rtl/aes_axis_rsp_collector.sv
// aes_axis_rsp_collector: RECV beat counter, framing check, optional watchdog (AES_AXIS_HOST_TIMEOUT_EN) and result assembly
module aes_axis_rsp_collector import aes_axis_host_pkg::*; #(
  parameter int TIMEOUT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              active_i,
  input  logic              tvalid_i,
  input  logic [WORD_S-1:0] tdata_i,
  input  logic              tlast_i,
  input  logic              clr_i,
  output logic              done_o,
  output logic              err_o,
  output logic [BLK_S-1:0]  data_o
);
  logic [1:0] k_q, k_d;
  logic [BLK_S-1:0] data_q, data_d;
  logic beat, last, to;
  assign beat = active_i && tvalid_i;
  assign last = k_q == 2'(RSP_FRAME_WORDS - 1);
`ifdef AES_AXIS_HOST_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (!active_i || beat) ? '0 : cnt_q + 1'b1;
  assign to = active_i && !beat && &cnt_q;
  always_ff @(posedge clk_i)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  localparam int unused_timeout_w = TIMEOUT_W;
  assign to = 1'b0;
`endif
  assign done_o = (beat && (tlast_i || last)) || to;
  assign err_o = done_o && !(beat && tlast_i && last);
  assign k_d = !active_i ? 2'd0 : beat ? k_q + 2'd1 : k_q;
  // words fill from the top; cleared slots stay zero on short frames
  assign data_d = clr_i ? '0 : beat ? data_q | ({byteswap(tdata_i), 96'b0} >> {k_q, 5'd0}) : data_q;
  assign data_o = data_q;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      k_q <= '0;
      data_q <= '0;
    end else begin
      k_q <= k_d;
      data_q <= data_d;
    end
endmodule

// File: rtl/aes_axis_host.sv
// aes_axis_host: serializes one request into a 5-beat AXIS command frame and returns the 4-beat response as 128 bits
// AES_AXIS_HOST_TIMEOUT_EN enables a TIMEOUT_W-bit response watchdog
module aes_axis_host import aes_axis_host_pkg::*; #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic                              axis_aclk,
  input  logic                              axis_aresetn,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [WORD_S-1:0]                 req_cmd,
  input  logic [BLK_S-1:0]                  req_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [BLK_S-1:0]                  rsp_data,
  output logic                              rsp_err,
  output logic                              m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready
);
  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [WORD_S-1:0] cmd_q, cmd_d, m_tdata_q;
  logic [BLK_S-1:0] data_q, data_d, shifted;
  logic req_ready_q, m_tvalid_q, m_tlast_q, s_tready_q, rsp_valid_q, rsp_err_q, rsp_err_d;
  logic done, err, rsp_hs, unused_strb;
  assign unused_strb = ^s00_axis_tstrb;
  assign rsp_hs = rsp_valid_q && rsp_ready;
  assign rsp_err_d = done ? err : rsp_err_q && !rsp_hs;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cmd_d = cmd_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        state_d = SEND;
        idx_d = '0;
        cmd_d = req_cmd;
        data_d = req_data;
      end
      SEND: if (m_tvalid_q && m00_axis_tready) begin
        state_d = m_tlast_q ? RECV : SEND;
        idx_d = m_tlast_q ? 3'd0 : idx_q + 3'd1;
      end
      RECV: if (done) state_d = RESP;
      default: if (rsp_hs) state_d = IDLE;
    endcase
  end
  // beat i>0 carries request word i-1, selected by shifting it to the top
  assign shifted = data_d << {idx_d - 3'd1, 5'd0};
  always_ff @(posedge axis_aclk)
    if (!axis_aresetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      cmd_q <= '0;
      data_q <= '0;
      req_ready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q <= '0;
      m_tlast_q <= 1'b0;
      s_tready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cmd_q <= cmd_d;
      data_q <= data_d;
      req_ready_q <= state_d == IDLE;
      m_tvalid_q <= state_d == SEND;
      m_tdata_q <= state_d != SEND ? '0 : idx_d == 3'd0 ? cmd_d : byteswap(shifted[BLK_S-1 -: WORD_S]);
      m_tlast_q <= state_d == SEND && idx_d == 3'(CMD_FRAME_WORDS - 1);
      s_tready_q <= state_d == RECV;
      rsp_valid_q <= state_d == RESP;
      rsp_err_q <= rsp_err_d;
    end
  aes_axis_rsp_collector #(.TIMEOUT_W(TIMEOUT_W)) u_rsp (
    .clk_i(axis_aclk),
    .rst_ni(axis_aresetn),
    .active_i(s_tready_q),
    .tvalid_i(s00_axis_tvalid),
    .tdata_i(s00_axis_tdata),
    .tlast_i(s00_axis_tlast),
    .clr_i(rsp_hs),
    .done_o(done),
    .err_o(err),
    .data_o(rsp_data)
  );
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = rsp_err_q;
  assign m00_axis_tvalid = m_tvalid_q;
  assign m00_axis_tdata = m_tdata_q;
  assign m00_axis_tstrb = '1;
  assign m00_axis_tlast = m_tlast_q;
  assign s00_axis_tready = s_tready_q;
endmodule

// File: doc/aes_axis_host.md
# aes_axis_host

Host-side endpoint of the AES AXI-Stream command interface: it accepts one parallel request (command word plus a 128-bit key or block) and serializes it as a 5-beat AXI-Stream frame to the AES engine. It then collects the engine's 4-beat response frame and returns it as one 128-bit result. It sits between a register or sequencer front end and the AES stream core, and is also the bench driver for system simulation.

## Interface
Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, master (command) bus width; only 32 supported
- C_S_AXIS_TDATA_WIDTH, 32, slave (response) bus width; only 32 supported
- TIMEOUT_W, 16, watchdog counter width (used only with AES_AXIS_HOST_TIMEOUT_EN)

Ports:
- axis_aclk  in  1  single clock for all logic
- axis_aresetn  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_cmd  in  32  command word (`ENCRYPT` / `SET_KEY`)
- req_data  in  128  key or plaintext, byte 0 = bits [127:120]
- rsp_valid  out  1  result present
- rsp_ready  in  1  result consumed
- rsp_data  out  128  result, byte 0 = bits [127:120]
- rsp_err  out  1  framing/timeout error, valid with rsp_valid
- m00_axis_tvalid / tdata[31:0] / tstrb[3:0] / tlast  out  command stream
- m00_axis_tready  in  1
- s00_axis_tvalid / tdata[31:0] / tstrb[3:0] / tlast  in  response stream
- s00_axis_tready  out  1

## Operation
- FSM states: IDLE, SEND, RECV, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture cmd/data and enter SEND with the beat index at 0.
- SEND: m00_axis_tvalid=1. tdata at index 0 = cmd; at index i (1..4) = byteswap(req_data[127-32(i-1) -: 32]). tlast=1 only at index 4. tstrb is all ones. The index advances on tvalid&&tready; on the tlast handshake, enter RECV with the index at 0.
- RECV: s00_axis_tready=1. Each beat stores byteswap(tdata) into rsp_data[127-32k -: 32], where k is the response beat index.
  - Normal completion: beat 3 has tlast=1. Enter RESP with err=0.
  - Early tlast (k<3): enter RESP with err=1. Unreceived words are 0.
  - Missing tlast at k=3: enter RESP with err=1. Later beats are not accepted.
- RESP: rsp_valid=1; rsp_data and rsp_err are held stable. On rsp_ready, clear rsp_data and rsp_err and return to IDLE.
- Every command, including SET_KEY, expects a 4-word response.
- The host is strictly one-request-in-flight. It does not overlap requests.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tlast=0, s00_axis_tready=0. State is IDLE and all counters are 0. req_ready rises in the cycle after reset deasserts.
- All stream outputs come from registers, with no combinational path from tready/tvalid to outputs. tdata for the next beat is updated in the same edge as the handshake.
- Request accept to first m00 beat valid: 1 cycle. With constant tready, the 5 beats take 5 consecutive cycles.
- Last s00 beat to rsp_valid: 1 cycle.
- Handshake rule: tvalid is not deasserted, and tdata/tlast do not change, while tvalid is high and tready is low.
- RESP to IDLE handshake: req_ready=1 in the cycle after the rsp_valid&&rsp_ready handshake. There is no bypass.
- Reset mid-frame: everything returns to reset values at the next edge. The partial frame is abandoned, with no tlast emitted.
- s00 beats arriving outside RECV are not accepted (tready=0).

## Configuration
- AES_AXIS_HOST_TIMEOUT_EN defined:
  - A TIMEOUT_W-bit counter runs in RECV. It clears on each accepted beat and on entry to RECV.
  - When the counter reaches all-ones, the FSM enters RESP with err=1 and the words received so far.
  - m00 back-pressure is not timed.
- Not defined: no counter exists. RECV waits indefinitely, and rsp_err reports only framing errors.

## Structure
- Shared header aes.vh provides `ENCRYPT`, `SET_KEY`, `WORD_S`, `BYTE_S` and `BLK_S`. Add `CMD_FRAME_WORDS` (5) and `RSP_FRAME_WORDS` (4) there.
- The byteswap function is shared with the stream core: move it into an include file, aes_func.vh.
- Sub-module aes_axis_rsp_collector owns the RECV beat counter, the framing check, the optional watchdog and the rsp_data assembly. It provides done and err strobes to the top FSM.

## Test plan
- SET_KEY with key 000102030405060708090a0b0c0d0e0f, tready=1:
  - m00 beats: `SET_KEY`, 03020100, 07060504, 0b0a0908, 0f0e0d0c; tlast on beat 5 only.
- ENCRYPT with plaintext 00112233445566778899aabbccddeeff:
  - Response beats d8e0c469, 30047b6a, 80b7cdd8, 5ac5b470 -> rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
- m00_axis_tready toggled 1/0 every cycle:
  - tdata/tlast stay stable while stalled; 5 beats complete in 10 cycles.
- Response with tlast on beat 2 (words 11111111, 22222222):
  - rsp_data=11111111_22222222_00000000_00000000, rsp_err=1.
- Response with 4 beats and no tlast -> rsp_err=1; a 5th beat is not accepted.
- Reset asserted during SEND beat 3 -> all outputs return to reset values at the next edge; the next request starts again from the cmd beat.
- With AES_AXIS_HOST_TIMEOUT_EN and TIMEOUT_W=4:
  - No response for 15 cycles -> rsp_valid=1, rsp_err=1.
